// File: rtl/ctr_stream_decryptor_pkg.sv
// Shared definitions for the CTR stream decryptor: block geometry and FSM states.
package ctr_stream_decryptor_pkg;

   localparam int BLOCK_BYTES = 16;
   localparam int BLOCK_BITS  = 128;
   localparam int BYTE_IDX_W  = 4;

   localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = BYTE_IDX_W'(BLOCK_BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DECRYPT = 2'd1,
      S_SEND    = 2'd2,
      S_DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/ctr_stream_decryptor_block_serializer.sv
// block_serializer: sends a 128-bit block as 16 UART bytes, LSB byte first,
// one byte per tx_start/tx_done handshake, and flags the final tx_done.
module block_serializer
   import ctr_stream_decryptor_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [BLOCK_BITS-1:0] data,
   input  logic                  tx_done,
   output logic [7:0]            tx_data,
   output logic                  tx_start,
   output logic                  last
);

   logic [BLOCK_BITS-1:0] shift_reg;
   logic [BYTE_IDX_W-1:0] byte_idx;
   logic                  active;

   assign last = active && tx_done && (byte_idx == LAST_BYTE_IDX);

   // Byte sequencing: byte 0 goes out on load, each later byte the cycle after tx_done
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_reg <= '0;
         byte_idx  <= '0;
         active    <= 1'b0;
         tx_data   <= '0;
         tx_start  <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         if (load) begin
            shift_reg <= data >> 8;
            tx_data   <= data[7:0];
            tx_start  <= 1'b1;
            byte_idx  <= '0;
            active    <= 1'b1;
         end else if (active && tx_done) begin
            if (byte_idx == LAST_BYTE_IDX) begin
               active <= 1'b0;
            end else begin
               byte_idx  <= byte_idx + 1'b1;
               tx_data   <= shift_reg[7:0];
               shift_reg <= shift_reg >> 8;
               tx_start  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ctr_stream_decryptor.sv
// ctr_stream_decryptor: assembles UART bytes into 128-bit blocks, hands them to
// an external decryption core and streams the plaintext back out over UART.
// Optional feature macro: BYTE_TIMEOUT_EN discards a stalled partial block.
module ctr_stream_decryptor
   import ctr_stream_decryptor_pkg::*;
#(
   parameter int NUM_BLOCKS     = 4,
   parameter int TIMEOUT_CYCLES = 8680
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_done,
   output logic [7:0]            tx_data,
   output logic                  tx_start,
   input  logic                  tx_done,
   output logic                  dec_start,
   output logic [BLOCK_BITS-1:0] dec_data_in,
   input  logic [BLOCK_BITS-1:0] dec_data_out,
   input  logic                  dec_done,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int BLK_W = $clog2(NUM_BLOCKS + 1);
   localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLOCKS - 1);

   state_t                state, state_next;
   logic [BYTE_IDX_W-1:0] byte_cnt;
   logic [BLOCK_BITS-9:0] asm_reg;
   logic [BLOCK_BITS-1:0] hold_reg;
   logic                  hold_full;
   logic [BLK_W-1:0]      blk_cnt;
   logic                  load_dec, release_hold, ser_load, blk_inc, blk_clr, ser_last;
   logic                  block_complete, timeout_hit;
   logic [BLOCK_BITS-1:0] block_word;

   assign block_complete = rx_done && (byte_cnt == LAST_BYTE_IDX);
   assign block_word     = {rx_data, asm_reg};
   assign done           = (state == S_DONE);

`ifdef BYTE_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] idle_cnt;

   assign timeout_hit = !rx_done && (byte_cnt != '0) && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Idle-cycle counter that runs only while a partial block is waiting
   always_ff @(posedge clk) begin
      if (reset || rx_done || byte_cnt == '0 || timeout_hit) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Byte assembler: little-endian packing, runs regardless of FSM state
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_cnt <= '0;
         asm_reg  <= '0;
      end else if (rx_done) begin
         if (block_complete) begin
            byte_cnt <= '0;
         end else begin
            asm_reg[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt <= byte_cnt + 1'b1;
         end
      end else if (timeout_hit) begin
         byte_cnt <= '0;
      end
   end

   // One-entry holding register; a release in the same cycle makes room for a new block
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_reg  <= '0;
         hold_full <= 1'b0;
      end else if (block_complete && (!hold_full || release_hold)) begin
         hold_reg  <= block_word;
         hold_full <= 1'b1;
      end else if (release_hold) begin
         hold_full <= 1'b0;
      end
   end

   // Sticky error: a block arriving at a still-occupied holding register, or a stalled partial block
   always_ff @(posedge clk) begin
      if (reset) begin
         error <= 1'b0;
      end else if ((block_complete && hold_full && !release_hold) || timeout_hit) begin
         error <= 1'b1;
      end
   end

   // Busy rises with any received byte and falls when the frame completes
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= 1'b0;
      end else if (rx_done) begin
         busy <= 1'b1;
      end else if (state == S_DONE) begin
         busy <= 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and control decode; strobes outside their expected state are ignored
   always_comb begin
      state_next   = state;
      load_dec     = 1'b0;
      release_hold = 1'b0;
      ser_load     = 1'b0;
      blk_inc      = 1'b0;
      blk_clr      = 1'b0;
      case (state)
         S_IDLE: begin
            if (hold_full) begin
               load_dec   = 1'b1;
               state_next = S_DECRYPT;
            end
         end
         S_DECRYPT: begin
            if (dec_done) begin
               release_hold = 1'b1;
               ser_load     = 1'b1;
               state_next   = S_SEND;
            end
         end
         S_SEND: begin
            if (ser_last) begin
               blk_inc    = 1'b1;
               state_next = (blk_cnt == LAST_BLK) ? S_DONE : S_IDLE;
            end
         end
         S_DONE: begin
            blk_clr    = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Core launch: ciphertext held stable from the start pulse until the core answers
   always_ff @(posedge clk) begin
      if (reset) begin
         dec_start   <= 1'b0;
         dec_data_in <= '0;
      end else begin
         dec_start <= load_dec;
         if (load_dec) begin
            dec_data_in <= hold_reg;
         end
      end
   end

   // Blocks-per-frame counter
   always_ff @(posedge clk) begin
      if (reset || blk_clr) begin
         blk_cnt <= '0;
      end else if (blk_inc) begin
         blk_cnt <= blk_cnt + 1'b1;
      end
   end

   block_serializer u_serializer (
      .clk      (clk),
      .reset    (reset),
      .load     (ser_load),
      .data     (dec_data_out),
      .tx_done  (tx_done),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .last     (ser_last)
   );

endmodule

// File: tb/tb_ctr_stream_decryptor.sv
// Self-checking bench for ctr_stream_decryptor with a bit-inverting core model
// and a UART transmitter model; expected blocks and bytes flow through queues.
module tb_ctr_stream_decryptor;

   localparam int NUM_BLOCKS     = 4;
   localparam int TIMEOUT_CYCLES = 100;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   rx_data;
   logic         rx_done;
   logic [7:0]   tx_data;
   logic         tx_start;
   logic         tx_done;
   logic         dec_start;
   logic [127:0] dec_data_in;
   logic [127:0] dec_data_out;
   logic         dec_done;
   logic         busy, done, error;

   logic tx_done_resp, tx_done_spur, dec_done_core, dec_done_spur;
   assign tx_done  = tx_done_resp | tx_done_spur;
   assign dec_done = dec_done_core | dec_done_spur;

   int checks = 0;
   int errors = 0;
   int tx_count = 0;
   int dec_count = 0;
   int done_count = 0;
   int core_latency = 3;

   logic [127:0] exp_blk_q[$];
   logic [7:0]   exp_tx_q[$];

   typedef struct {
      logic [7:0]   first;
      logic [7:0]   stride;
      logic [127:0] exp_block;
   } vec_t;

   vec_t vecs[NUM_BLOCKS];

   ctr_stream_decryptor #(
      .NUM_BLOCKS     (NUM_BLOCKS),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_done      (rx_done),
      .tx_data      (tx_data),
      .tx_start     (tx_start),
      .tx_done      (tx_done),
      .dec_start    (dec_start),
      .dec_data_in  (dec_data_in),
      .dec_data_out (dec_data_out),
      .dec_done     (dec_done),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] packSeq(input logic [7:0] first, input logic [7:0] stride);
      logic [127:0] r;
      logic [7:0]   b;
      r = '0;
      b = first;
      for (int i = 0; i < 16; i++) begin
         r[i*8 +: 8] = b;
         b = b + stride;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_tx_data"},     128'(tx_data), 128'd0);
      checkOutput({tag, "_tx_start"},    128'(tx_start), 128'd0);
      checkOutput({tag, "_dec_start"},   128'(dec_start), 128'd0);
      checkOutput({tag, "_dec_data_in"}, dec_data_in, 128'd0);
      checkOutput({tag, "_busy"},        128'(busy), 128'd0);
      checkOutput({tag, "_done"},        128'(done), 128'd0);
      checkOutput({tag, "_error"},       128'(error), 128'd0);
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic sendBlock(input logic [7:0] first, input logic [7:0] stride,
                            input logic expect_it, input logic [127:0] exp);
      logic [7:0] b;
      if (expect_it) exp_blk_q.push_back(exp);
      b = first;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(b);
         b = b + stride;
      end
   endtask

   task automatic waitTx(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (tx_count < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      checkOutput(name, 128'(tx_count), 128'(target));
      checkOutput({name, "_queue_empty"}, 128'(exp_tx_q.size()), 128'd0);
   endtask

   task automatic resetDut();
      @(negedge clk);
      reset = 1'b1;
      rx_done = 1'b0;
      exp_blk_q.delete();
      exp_tx_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Decryption core model: inverts the ciphertext after core_latency cycles
   initial begin : core_model
      logic [127:0] held, exp_cur;
      int cnt;
      dec_done_core = 1'b0;
      dec_data_out  = '0;
      held = '0;
      exp_cur = '0;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            dec_done_core = 1'b0;
            cnt = 0;
         end else begin
            dec_done_core = 1'b0;
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  checkOutput("dec_in_stable", dec_data_in, held);
                  dec_data_out  = ~held;
                  dec_done_core = 1'b1;
                  for (int i = 0; i < 16; i++) exp_tx_q.push_back(~exp_cur[i*8 +: 8]);
               end
            end
            if (dec_start) begin
               dec_count++;
               if (exp_blk_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_dec_start actual=1 expected=0");
                  exp_cur = '0;
               end else begin
                  exp_cur = exp_blk_q.pop_front();
                  checkOutput("dec_data_in", dec_data_in, exp_cur);
               end
               held = dec_data_in;
               cnt  = core_latency;
            end
         end
      end
   end

   // UART transmitter model: acknowledges each tx_start two cycles later
   initial begin : tx_model
      logic [7:0] held;
      int pend;
      tx_done_resp = 1'b0;
      held = '0;
      pend = 0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            tx_done_resp = 1'b0;
            pend = 0;
         end else begin
            tx_done_resp = 1'b0;
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  checkOutput("tx_stable", 128'(tx_data), 128'(held));
                  tx_done_resp = 1'b1;
               end
            end
            if (tx_start) begin
               tx_count++;
               if (exp_tx_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_tx_start actual=%0h expected=none", tx_data);
               end else begin
                  checkOutput("tx_byte", 128'(tx_data), 128'(exp_tx_q.pop_front()));
               end
               held = tx_data;
               pend = 2;
            end
         end
      end
   end

   // Done pulse counter
   initial begin : done_monitor
      forever begin
         @(posedge clk);
         #1;
         if (!reset && done) done_count++;
      end
   end

   // Watchdog so the run always ends
   initial begin : watchdog
      #900000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int n, base_tx, base_dec;
      logic saw;
      reset = 1'b1;
      rx_data = '0;
      rx_done = 1'b0;
      tx_done_spur = 1'b0;
      dec_done_spur = 1'b0;

      vecs[0] = '{8'h00, 8'h01, 128'h0F0E0D0C0B0A09080706050403020100};
      vecs[1] = '{8'hA5, 8'h03, packSeq(8'hA5, 8'h03)};
      vecs[2] = '{8'h3C, 8'hF1, packSeq(8'h3C, 8'hF1)};
      vecs[3] = '{8'hFF, 8'h00, packSeq(8'hFF, 8'h00)};

      repeat (3) @(negedge clk);
      checkResetValues("reset");
      reset = 1'b0;

      // Spurious strobes in idle must be ignored
      @(negedge clk);
      tx_done_spur = 1'b1;
      @(negedge clk);
      tx_done_spur = 1'b0;
      dec_done_spur = 1'b1;
      @(negedge clk);
      dec_done_spur = 1'b0;
      saw = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (tx_start || dec_start || busy || done) saw = 1'b1;
      end
      checkOutput("spurious_quiet", 128'(saw), 128'd0);

      // Full frame from the vector table
      for (int i = 0; i < NUM_BLOCKS; i++) begin
         sendBlock(vecs[i].first, vecs[i].stride, 1'b1, vecs[i].exp_block);
         if (i == 0) checkOutput("busy_mid_frame", 128'(busy), 128'd1);
      end
      n = 0;
      while (done_count == 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("frame_tx_at_done", 128'(tx_count), 128'd64);
      repeat (10) @(negedge clk);
      checkOutput("frame_done_pulses", 128'(done_count), 128'd1);
      checkOutput("frame_busy_after", 128'(busy), 128'd0);
      checkOutput("frame_error", 128'(error), 128'd0);
      checkOutput("frame_queue_empty", 128'(exp_tx_q.size()), 128'd0);

      // Overrun: core stalls while two more blocks arrive
      core_latency = 2000;
      base_tx  = tx_count;
      base_dec = dec_count;
      sendBlock(8'h40, 8'h01, 1'b1, packSeq(8'h40, 8'h01));
      sendBlock(8'h80, 8'h01, 1'b0, '0);
      sendBlock(8'hC0, 8'h01, 1'b0, '0);
      checkOutput("overrun_error", 128'(error), 128'd1);
      waitTx(base_tx + 16, 3000, "overrun_tx_count");
      checkOutput("overrun_dec_count", 128'(dec_count - base_dec), 128'd1);
      checkOutput("overrun_error_sticky", 128'(error), 128'd1);
      core_latency = 3;

      // Reset in the middle of block 2 of a frame
      resetDut();
      checkOutput("reset_clears_error", 128'(error), 128'd0);
      base_tx = tx_count;
      sendBlock(vecs[1].first, vecs[1].stride, 1'b1, vecs[1].exp_block);
      sendBlock(vecs[2].first, vecs[2].stride, 1'b1, vecs[2].exp_block);
      n = 0;
      while (tx_count < base_tx + 24 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reset_reach_b2_byte8", 128'(tx_count - base_tx), 128'd24);
      reset = 1'b1;
      exp_blk_q.delete();
      exp_tx_q.delete();
      @(posedge clk);
      #1;
      checkResetValues("midreset");
      @(negedge clk);
      reset = 1'b0;
      saw = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (tx_start || dec_start || done) saw = 1'b1;
      end
      checkOutput("midreset_quiet", 128'(saw), 128'd0);
      base_tx = tx_count;
      sendBlock(8'h10, 8'h11, 1'b1, packSeq(8'h10, 8'h11));
      waitTx(base_tx + 16, 500, "fresh_tx_count");
      checkOutput("fresh_busy_partial_frame", 128'(busy), 128'd1);
      checkOutput("fresh_error", 128'(error), 128'd0);

`ifdef BYTE_TIMEOUT_EN
      // Partial block times out; following bytes start a fresh block
      resetDut();
      for (int i = 1; i <= 5; i++) applyStimulus(8'(i));
      repeat (TIMEOUT_CYCLES + 1) @(negedge clk);
      checkOutput("timeout_error", 128'(error), 128'd1);
      base_tx = tx_count;
      sendBlock(8'h06, 8'h01, 1'b1, packSeq(8'h06, 8'h01));
      waitTx(base_tx + 16, 500, "timeout_tx_count");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctr_stream_decryptor.md
CTR_STREAM_DECRYPTOR -- requirements
Module: ctr_stream_decryptor

Interface
REQ-001 Parameter NUM_BLOCKS, default 4: number of 128-bit blocks per frame (8x8 image / 16).
REQ-002 Parameter TIMEOUT_CYCLES, default 8680: idle-byte limit in clk cycles (about 20 bit times at 50 MHz / 115200).
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rx_data  in  8  received UART byte; valid only while rx_done=1.
REQ-006 rx_done  in  1  one-cycle byte-received strobe.
REQ-007 tx_data  out  8  byte to transmit.
REQ-008 tx_start  out  1  one-cycle transmit request.
REQ-009 tx_done  in  1  one-cycle byte-sent strobe.
REQ-010 dec_start  out  1  one-cycle decryption-core start pulse.
REQ-011 dec_data_in  out  128  ciphertext block to the core.
REQ-012 dec_data_out  in  128  plaintext block; valid while dec_done=1.
REQ-013 dec_done  in  1  one-cycle core completion strobe.
REQ-014 busy  out  1  high from the first accepted byte until the frame ends.
REQ-015 done  out  1  one-cycle pulse after the last byte of the frame is sent.
REQ-016 error  out  1  sticky overrun/timeout flag, cleared only by reset.

Function
REQ-017 The assembler SHALL pack bytes little-endian: the first byte of a block goes to bits [7:0] and the 16th byte to [127:120].
REQ-018 The assembler SHALL accept rx bytes in every state, so reception is independent of decryption and transmission.
REQ-019 On the 16th byte, the assembler SHALL move the block into a one-entry holding register and mark it full in the same cycle.
REQ-020 If the holding register is full when a 16th byte completes a block, the block SHALL be dropped, error set, and the byte counter cleared.
REQ-021 The FSM SHALL have the states S_IDLE, S_DECRYPT, S_SEND and S_DONE.
REQ-022 S_IDLE -> S_DECRYPT when the holding register is full; dec_data_in SHALL be loaded and dec_start pulsed in the transition cycle.
REQ-023 dec_data_in SHALL stay stable until dec_done.
REQ-024 On dec_done, the FSM SHALL capture dec_data_out, free the holding register and enter S_SEND.
REQ-025 In S_SEND the serializer SHALL issue byte 0 (bits [7:0]) on the entry cycle, then each next byte on the cycle after tx_done, 16 bytes LSB first.
REQ-026 tx_data SHALL be stable from its tx_start until the matching tx_done.
REQ-027 After the 16th tx_done, the FSM SHALL increment the block counter. If the count equals NUM_BLOCKS it goes to S_DONE, otherwise to S_IDLE.
REQ-028 S_DONE SHALL pulse done for one cycle, clear the block counter and busy, and return to S_IDLE.
REQ-029 A dec_done or tx_done arriving in a state that does not expect it SHALL be ignored.
REQ-030 A simultaneous rx_done and holding-register release in the same cycle SHALL count as no overrun.

Reset
REQ-031 On reset: tx_data=0, tx_start=0, dec_start=0, dec_data_in=0, busy=0, done=0, error=0; FSM in S_IDLE; byte, tx and block counters =0; holding register empty.
REQ-032 Reset asserted mid-frame SHALL abort all activity the next cycle with no further strobes.

Configuration
REQ-033 With BYTE_TIMEOUT_EN defined, a partial block (1 to 15 bytes) with no rx_done for TIMEOUT_CYCLES SHALL be discarded: byte counter cleared, error set.
REQ-034 Without BYTE_TIMEOUT_EN, no timeout counter SHALL exist and a partial block SHALL wait indefinitely.

Structure
REQ-035 The shared package SHALL hold the FSM state encoding, BLOCK_BYTES=16 and BLOCK_BITS=128.
REQ-036 A sub-module block_serializer (128-bit load, tx_start/tx_done handshake, last-byte strobe) SHALL implement S_SEND byte sequencing.

Verification
REQ-037 Feed 16 bytes 0x00..0x0F with dec_data_out = input XOR all-ones -> dec_data_in=0x0F0E..0100, tx bytes 0xFF,0xFE..0xF0 in order.
REQ-038 Full frame of 64 bytes with NUM_BLOCKS=4 -> 64 tx bytes, exactly one done pulse after the 64th tx_done, busy low afterwards.
REQ-039 Stall dec_done for 2000 cycles while 32 more bytes arrive -> the second block is dropped and error=1.
REQ-040 BYTE_TIMEOUT_EN defined, send 5 bytes then idle TIMEOUT_CYCLES+1 -> error=1; the next 16 bytes form a block starting at the 6th-sent byte.
REQ-041 Assert reset at the 8th tx byte of block 2 -> all outputs at reset values next cycle; a fresh 16-byte frame decrypts correctly.
REQ-042 Spurious tx_done and dec_done pulses in S_IDLE -> no state change and no tx_start.
